// File: rtl/game_pkg.sv
// Shared game-state encoding for the round sequencer and the high-score/display block.
package game_pkg;

  typedef enum logic [2:0] {
    ModeIdle      = 3'b000,
    ModeCountdown = 3'b001,
    ModePlay      = 3'b010,
    ModePause     = 3'b011,
    ModeFinish    = 3'b101
  } game_mode_t;

  localparam logic [7:0] BcdMax = 8'h99;

endpackage

// File: rtl/game_round_ctrl_if.sv
// Event inputs and round status outputs of the round sequencer.
interface game_round_ctrl_if;

  logic                 start;
  logic                 hit_evt;
  logic                 miss_evt;
  logic                 song_done;
  game_pkg::game_mode_t mode;
  logic [7:0]           score;
  logic [7:0]           hits;
  logic [7:0]           misses;
  logic                 combo_on;
  logic                 note_run;

  modport master (
    output start, hit_evt, miss_evt, song_done,
    input  mode, score, hits, misses, combo_on, note_run
  );

  modport slave (
    input  start, hit_evt, miss_evt, song_done,
    output mode, score, hits, misses, combo_on, note_run
  );

endinterface

// File: rtl/bcd2_sat_add.sv
// Two-digit BCD add of a small increment, clamped at 8'h99.
module bcd2_sat_add (
  input  logic [7:0] a_i,
  input  logic [1:0] inc_i,
  output logic [7:0] sum_o
);

  logic [4:0] units_sum;
  logic [3:0] units_adj;
  logic       carry;
  logic [4:0] tens_sum;

  always_comb begin
    units_sum = {1'b0, a_i[3:0]} + {3'b000, inc_i};
    carry     = (units_sum > 5'd9);
    units_adj = carry ? 4'(units_sum - 5'd10) : units_sum[3:0];
    tens_sum  = {1'b0, a_i[7:4]} + {4'b0000, carry};
    sum_o     = (tens_sum > 5'd9) ? 8'h99 : {tens_sum[3:0], units_adj};
  end

endmodule

// File: rtl/sync_posedge.sv
// Two-flop synchronizer for an asynchronous level, producing a one-cycle pulse on its rising edge.
module sync_posedge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic posout_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= in_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign posout_o = sync_q & ~prev_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer: owns the game mode, the countdown and the BCD score/hits/misses counters,
// and gates the note scroller while a round is in play.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CountCycles = 50_000_000,
  parameter int unsigned ComboLen    = 5,
  parameter logic [7:0]  MaxMisses   = 8'h20
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  game_round_ctrl_if.slave bus
);

  localparam int unsigned CntW    = $clog2(CountCycles + 1);
  localparam int unsigned StreakW = $clog2(ComboLen + 1);
  localparam logic [CntW-1:0]    CntLoad   = CntW'(CountCycles - 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(ComboLen);

  game_mode_t         mode_q, mode_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [7:0]         score_q, score_d;
  logic [7:0]         hits_q, hits_d;
  logic [7:0]         misses_q, misses_d;
  logic               combo_q, note_run_q;

  logic       press;
  logic       play_hit, play_miss;
  logic [1:0] score_inc, hits_inc, misses_inc;
  logic [7:0] score_sum, hits_sum, misses_sum;
  logic       miss_limit;

  sync_posedge u_start_sync (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .in_i     (bus.start),
    .posout_o (press)
  );

  // Events only count while playing; a simultaneous hit and miss scores a plain point.
  always_comb begin
    play_hit   = (mode_q == ModePlay) & bus.hit_evt;
    play_miss  = (mode_q == ModePlay) & bus.miss_evt;
    hits_inc   = {1'b0, play_hit};
    misses_inc = {1'b0, play_miss};
    score_inc  = 2'd0;
    if (play_hit) begin
      score_inc = (!play_miss && (streak_q == StreakMax)) ? 2'd2 : 2'd1;
    end
  end

  bcd2_sat_add u_score_add (
    .a_i   (score_q),
    .inc_i (score_inc),
    .sum_o (score_sum)
  );

  bcd2_sat_add u_hits_add (
    .a_i   (hits_q),
    .inc_i (hits_inc),
    .sum_o (hits_sum)
  );

  bcd2_sat_add u_misses_add (
    .a_i   (misses_q),
    .inc_i (misses_inc),
    .sum_o (misses_sum)
  );

  assign miss_limit = (MaxMisses != 8'h00) && (misses_sum >= MaxMisses);

  always_comb begin
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    streak_d = streak_q;
    score_d  = score_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    case (mode_q)
      ModeIdle: begin
        if (press) begin
          mode_d   = ModeCountdown;
          cnt_d    = CntLoad;
          streak_d = '0;
          score_d  = 8'h00;
          hits_d   = 8'h00;
          misses_d = 8'h00;
        end
      end
      ModeCountdown: begin
        if (cnt_q == '0) begin
          mode_d = ModePlay;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ModePlay: begin
        score_d  = score_sum;
        hits_d   = hits_sum;
        misses_d = misses_sum;
        if (play_miss) begin
          streak_d = '0;
        end else if (play_hit && (streak_q != StreakMax)) begin
          streak_d = streak_q + StreakW'(1);
        end
        // Finishing outranks a pause requested on the same edge.
        if (bus.song_done || miss_limit) begin
          mode_d = ModeFinish;
        end else if (press) begin
          mode_d = ModePause;
        end
      end
      ModePause: begin
        if (press) begin
          mode_d = ModePlay;
        end
      end
      ModeFinish: begin
        if (press) begin
          mode_d = ModeIdle;
        end
      end
      default: begin
        mode_d = ModeIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q     <= ModeIdle;
      cnt_q      <= '0;
      streak_q   <= '0;
      score_q    <= 8'h00;
      hits_q     <= 8'h00;
      misses_q   <= 8'h00;
      combo_q    <= 1'b0;
      note_run_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      score_q    <= score_d;
      hits_q     <= hits_d;
      misses_q   <= misses_d;
      combo_q    <= (streak_d == StreakMax);
      note_run_q <= (mode_d == ModePlay);
    end
  end

  assign bus.mode     = mode_q;
  assign bus.score    = score_q;
  assign bus.hits     = hits_q;
  assign bus.misses   = misses_q;
  assign bus.combo_on = combo_q;
  assign bus.note_run = note_run_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized bench for game_round_ctrl against an integer-arithmetic model of the round rules.
module tb_game_round_ctrl;
  import game_pkg::*;

  localparam int unsigned CountCycles = 4;
  localparam int unsigned ComboLen    = 3;
  localparam logic [7:0]  MaxMisses   = 8'h05;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  game_round_ctrl_if bus ();

  game_round_ctrl #(
    .CountCycles (CountCycles),
    .ComboLen    (ComboLen),
    .MaxMisses   (MaxMisses)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  game_mode_t m_mode;
  int m_score, m_hits, m_misses, m_streak;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int sat99(input int v);
    return (v > 99) ? 99 : v;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "/mode"}, 32'(bus.mode), 32'(m_mode));
    check_eq({tag, "/score"}, 32'(bus.score), 32'(to_bcd(m_score)));
    check_eq({tag, "/hits"}, 32'(bus.hits), 32'(to_bcd(m_hits)));
    check_eq({tag, "/misses"}, 32'(bus.misses), 32'(to_bcd(m_misses)));
    check_eq({tag, "/combo"}, 32'(bus.combo_on), 32'(m_streak == int'(ComboLen)));
    check_eq({tag, "/note_run"}, 32'(bus.note_run), 32'(m_mode == ModePlay));
  endtask

  task automatic model_reset();
    m_mode   = ModeIdle;
    m_score  = 0;
    m_hits   = 0;
    m_misses = 0;
    m_streak = 0;
  endtask

  // One cycle of judge pulses, then the model advances by the game rules.
  task automatic step(input bit hit, input bit miss, input bit song);
    @(negedge clk);
    bus.hit_evt   = hit;
    bus.miss_evt  = miss;
    bus.song_done = song;
    @(posedge clk);
    #1;
    bus.hit_evt   = 1'b0;
    bus.miss_evt  = 1'b0;
    bus.song_done = 1'b0;
    if (m_mode == ModePlay) begin
      if (hit) begin
        m_hits  = sat99(m_hits + 1);
        m_score = sat99(m_score + ((!miss && m_streak >= int'(ComboLen)) ? 2 : 1));
      end
      if (miss) begin
        m_misses = sat99(m_misses + 1);
        m_streak = 0;
      end else if (hit && m_streak < int'(ComboLen)) begin
        m_streak = m_streak + 1;
      end
      if (song || (from_bcd(MaxMisses) != 0 && m_misses >= from_bcd(MaxMisses))) begin
        m_mode = ModeFinish;
      end
    end
    check_all("step");
  endtask

  task automatic press();
    game_mode_t target;
    bit got;
    target = m_mode;
    case (m_mode)
      ModeIdle:   target = ModeCountdown;
      ModePlay:   target = ModePause;
      ModePause:  target = ModePlay;
      ModeFinish: target = ModeIdle;
      default:    target = m_mode;
    endcase
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.mode == target) begin
        got = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    if (target == ModeCountdown) begin
      m_score  = 0;
      m_hits   = 0;
      m_misses = 0;
      m_streak = 0;
    end
    m_mode = target;
    check_eq("press_seen", 32'(got), 32'd1);
    check_all("press");
  endtask

  // Call right after a press that entered the countdown; that sample is its first cycle.
  task automatic run_countdown();
    int n;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.mode == ModeCountdown) n++;
      else break;
    end
    check_eq("countdown_len", 32'(n), 32'(CountCycles));
    m_mode = ModePlay;
    check_all("play_entry");
  endtask

  task automatic to_play();
    if (m_mode == ModeFinish) press();
    if (m_mode == ModeIdle) begin
      press();
      run_countdown();
    end
    if (m_mode == ModePause) press();
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.hit_evt   = 1'b0;
    bus.miss_evt  = 1'b0;
    bus.song_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    press();
    run_countdown();

    repeat (5) step(1'b1, 1'b0, 1'b0);
    check_eq("score_5hits", 32'(bus.score), 32'h07);
    check_eq("hits_5hits", 32'(bus.hits), 32'h05);
    step(1'b0, 1'b1, 1'b0);
    check_eq("combo_after_miss", 32'(bus.combo_on), 32'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check_eq("combo_rebuilt", 32'(bus.combo_on), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check_eq("hitmiss_score", 32'(bus.score), 32'h11);
    check_eq("hitmiss_hits", 32'(bus.hits), 32'h09);

    press();
    repeat (4) step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)));
    check_eq("pause_mode", 32'(bus.mode), 32'(ModePause));
    press();
    step(1'b1, 1'b0, 1'b0);
    check_eq("hits_bcd_carry", 32'(bus.hits), 32'h10);

    for (int i = 0; i < 100 && m_score < 98; i++) step(1'b1, 1'b0, 1'b0);
    check_eq("score_98", 32'(bus.score), 32'h98);
    check_eq("combo_at_98", 32'(bus.combo_on), 32'd1);
    step(1'b1, 1'b0, 1'b0);
    check_eq("score_clamp", 32'(bus.score), 32'h99);
    step(1'b1, 1'b0, 1'b0);
    check_eq("score_hold", 32'(bus.score), 32'h99);
    repeat (50) step(1'b1, 1'b0, 1'b0);
    check_eq("hits_sat", 32'(bus.hits), 32'h99);

    repeat (3) step(1'b0, 1'b1, 1'b0);
    check_eq("limit_mode", 32'(bus.mode), 32'(ModeFinish));
    check_eq("limit_misses", 32'(bus.misses), 32'h05);
    step(1'b1, 1'b1, 1'b1);
    press();
    check_eq("idle_hold_misses", 32'(bus.misses), 32'h05);
    press();
    check_eq("cleared_score", 32'(bus.score), 32'h00);
    run_countdown();

    for (int i = 0; i < 600; i++) begin
      if (m_mode == ModePlay) begin
        if ($urandom_range(0, 99) < 3) begin
          press();
          repeat (2) step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b0);
          press();
        end else begin
          step(bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 79) == 0));
        end
      end else begin
        to_play();
      end
    end

    to_play();
    repeat (4) step(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
